// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: frame bit indices, prescale limits and the
// three-sample majority vote; also used by the start/parity/stop checkers.
package uart_rx_pkg;

  typedef logic [3:0] bit_idx_t;

  localparam bit_idx_t BIT_START      = 4'd0;
  localparam bit_idx_t BIT_PARITY     = 4'd9;
  localparam bit_idx_t BIT_STOP_PAR   = 4'd10;
  localparam bit_idx_t BIT_STOP_NOPAR = 4'd9;
  localparam bit_idx_t BIT_IDX_MAX    = 4'd15;

  localparam int PRESCALE_MIN       = 8;
  localparam int DEFAULT_PRESCALE_W = 6;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_bit_sampler_if.sv
// Signal bundle between the RX FSM (master) and the bit sampler (slave).
// Noise_Flag is present only when RX_NOISE_FLAG_EN is defined.
interface rx_bit_sampler_if import uart_rx_pkg::*; #(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
);

  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  Enable;
  logic                  RX_Sync;
  logic [PRESCALE_W-1:0] Edge_Count;
  bit_idx_t              Bit_Counts;
  logic                  Sampled_Bit;
  logic                  Sample_Valid;
`ifdef RX_NOISE_FLAG_EN
  logic                  Noise_Flag;
`endif

  modport master (
    output RX_IN, Prescale, Enable,
    input  RX_Sync, Edge_Count, Bit_Counts, Sampled_Bit, Sample_Valid
`ifdef RX_NOISE_FLAG_EN
    , input Noise_Flag
`endif
  );

  modport slave (
    input  RX_IN, Prescale, Enable,
    output RX_Sync, Edge_Count, Bit_Counts, Sampled_Bit, Sample_Valid
`ifdef RX_NOISE_FLAG_EN
    , output Noise_Flag
`endif
  );

endinterface

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the raw RX line, both stages resetting to idle-high.
// Latency 2 CLK; no flow control.
module rx_sync (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [1:0] stage_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) stage_q <= 2'b11;
    else      stage_q <= {stage_q[0], d};
  end

  assign q = stage_q[1];

endmodule

// File: rtl/rx_bit_sampler.sv
// UART RX bit sampler: synchronise, count edges/bits, majority-vote 3 mid-bit samples.
// Sample_Valid pulses 1 cycle after the vote edge; no backpressure. Option: RX_NOISE_FLAG_EN.
module rx_bit_sampler import uart_rx_pkg::*; #(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input logic             CLK,
  input logic             RST,
  rx_bit_sampler_if.slave bus
);

  localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(PRESCALE_MIN);
  localparam logic [PRESCALE_W-1:0] W_ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] W_TWO = PRESCALE_W'(2);

  logic                  rx_sync_q;
  logic                  enable_q;
  logic                  s0_q, s1_q;
  logic                  sampled_q, valid_q;
  logic [PRESCALE_W-1:0] p_q, p_new, p_eff, half, edge_cnt_q;
  bit_idx_t              bit_cnt_q;
  logic                  rise, at_s0, at_s1, at_vote, at_wrap, vote;
`ifdef RX_NOISE_FLAG_EN
  logic                  noise_q;
`endif

  rx_sync u_rx_sync (.CLK(CLK), .RST(RST), .d(bus.RX_IN), .q(rx_sync_q));

  // On the rising cycle the period is taken straight from Prescale so the
  // first bit already uses the new value.
  always_comb begin
    rise    = bus.Enable & ~enable_q;
    p_new   = (bus.Prescale < P_MIN) ? P_MIN : bus.Prescale;
    p_eff   = rise ? p_new : p_q;
    half    = p_eff >> 1;
    at_s0   = (edge_cnt_q == half - W_TWO);
    at_s1   = (edge_cnt_q == half - W_ONE);
    at_vote = (edge_cnt_q == half);
    at_wrap = (edge_cnt_q >= p_eff - W_ONE);
    vote    = maj3(s0_q, s1_q, rx_sync_q);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      enable_q   <= 1'b0;
      p_q        <= P_MIN;
      edge_cnt_q <= '0;
      bit_cnt_q  <= BIT_START;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      sampled_q  <= 1'b1;
      valid_q    <= 1'b0;
`ifdef RX_NOISE_FLAG_EN
      noise_q    <= 1'b0;
`endif
    end else begin
      enable_q <= bus.Enable;
      if (rise) p_q <= p_new;
      if (!bus.Enable) begin
        edge_cnt_q <= '0;
        bit_cnt_q  <= BIT_START;
        s0_q       <= 1'b1;
        s1_q       <= 1'b1;
        valid_q    <= 1'b0;
`ifdef RX_NOISE_FLAG_EN
        noise_q    <= 1'b0;
`endif
      end else begin
        if (at_wrap) begin
          edge_cnt_q <= '0;
          if (bit_cnt_q != BIT_IDX_MAX) bit_cnt_q <= bit_cnt_q + 4'd1;
        end else begin
          edge_cnt_q <= edge_cnt_q + W_ONE;
        end
        if (at_s0) s0_q <= rx_sync_q;
        if (at_s1) s1_q <= rx_sync_q;
        valid_q <= at_vote;
        if (at_vote) begin
          sampled_q <= vote;
`ifdef RX_NOISE_FLAG_EN
          noise_q   <= ~((s0_q == s1_q) && (s1_q == rx_sync_q));
`endif
        end
      end
    end
  end

  assign bus.RX_Sync      = rx_sync_q;
  assign bus.Edge_Count   = edge_cnt_q;
  assign bus.Bit_Counts   = bit_cnt_q;
  assign bus.Sampled_Bit  = sampled_q;
  assign bus.Sample_Valid = valid_q;
`ifdef RX_NOISE_FLAG_EN
  assign bus.Noise_Flag   = noise_q;
`endif

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Directed bench for rx_bit_sampler: frame table plus hand-written corner sequences.
module tb_rx_bit_sampler;

  localparam int PW = 6;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  rx_bit_sampler_if #(.PRESCALE_W(PW)) bus ();
  rx_bit_sampler #(.PRESCALE_W(PW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct {
    int          prescale;
    int          p_eff;
    int          mid_prescale;
    logic [10:0] pin;
    int          nbits;
    logic [10:0] exp_bits;
    int          glitch_bit;
    int          glitch_edge;
  } frame_t;

  frame_t vec [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int p);
    bus.Enable   = 1'b0;
    bus.RX_IN    = 1'b1;
    bus.Prescale = PW'(p);
    repeat (3) step();
  endtask

  // Pin cycle t drives bit t/P; Enable rises at t=2, when RX_Sync first shows
  // the start edge, so the cycle observed after step t has Edge_Count (t-1)%P.
  task automatic run_frame(input frame_t f);
    int h, r, b, pulses;
    h      = f.p_eff / 2;
    pulses = 0;
    idle(f.prescale);
    for (int t = 0; t < f.nbits * f.p_eff; t++) begin
      b = t / f.p_eff;
      bus.RX_IN  = f.pin[b] ^ ((b == f.glitch_bit) && ((t % f.p_eff) == f.glitch_edge));
      bus.Enable = (t >= 2);
      if (f.mid_prescale != 0 && t == 3 * f.p_eff) bus.Prescale = PW'(f.mid_prescale);
      step();
      r = t - 1;
      chk("edge_count", int'(bus.Edge_Count), (r < 0) ? 0 : r % f.p_eff);
      if (r >= 0 && (r % f.p_eff) == h + 1) begin
        pulses++;
        chk("sample_valid", int'(bus.Sample_Valid), 1);
        chk("sampled_bit", int'(bus.Sampled_Bit), int'(f.exp_bits[r / f.p_eff]));
        chk("bit_counts", int'(bus.Bit_Counts), r / f.p_eff);
`ifdef RX_NOISE_FLAG_EN
        chk("noise_flag", int'(bus.Noise_Flag), int'((r / f.p_eff) == f.glitch_bit));
`endif
      end else begin
        chk("no_pulse", int'(bus.Sample_Valid), 0);
      end
    end
    chk("pulse_count", pulses, f.nbits);
    bus.Enable = 1'b0;
    bus.RX_IN  = 1'b1;
    step();
    chk("drop_edge", int'(bus.Edge_Count), 0);
    chk("drop_bits", int'(bus.Bit_Counts), 0);
    chk("drop_valid", int'(bus.Sample_Valid), 0);
    chk("drop_hold", int'(bus.Sampled_Bit), int'(f.exp_bits[f.nbits - 1]));
`ifdef RX_NOISE_FLAG_EN
    chk("drop_noise", int'(bus.Noise_Flag), 0);
`endif
  endtask

  initial begin
    logic [10:0] pin;

    vec[0] = '{8,  8,  0,  {1'b0, 1'b1, 8'h55, 1'b0}, 10, 11'b01010101010, -1, 0};
    vec[1] = '{16, 16, 0,  {1'b1, 1'b0, 8'hA3, 1'b0}, 11, 11'b10101000110, -1, 0};
    vec[2] = '{8,  8,  0,  {1'b0, 1'b1, 8'hFF, 1'b0}, 10, 11'b01111111110, 1,  3};
    vec[3] = '{8,  8,  32, {1'b0, 1'b1, 8'h0F, 1'b0}, 10, 11'b01000011110, -1, 0};
    vec[4] = '{32, 32, 0,  {1'b0, 1'b1, 8'hF0, 1'b0}, 10, 11'b01111100000, -1, 0};
    vec[5] = '{3,  8,  0,  {1'b0, 1'b1, 8'h96, 1'b0}, 10, 11'b01100101100, -1, 0};

    RST          = 1'b0;
    bus.Enable   = 1'b0;
    bus.RX_IN    = 1'b1;
    bus.Prescale = PW'(8);
    repeat (3) @(posedge CLK);
    #3 RST = 1'b1;
    step();
    step();
    chk("rst_rx_sync", int'(bus.RX_Sync), 1);
    chk("rst_edge", int'(bus.Edge_Count), 0);
    chk("rst_bits", int'(bus.Bit_Counts), 0);
    chk("rst_sampled", int'(bus.Sampled_Bit), 1);
    chk("rst_valid", int'(bus.Sample_Valid), 0);
`ifdef RX_NOISE_FLAG_EN
    chk("rst_noise", int'(bus.Noise_Flag), 0);
`endif

    for (int i = 0; i < 6; i++) run_frame(vec[i]);

    // Bit_Counts saturates at 15 with Enable held high.
    idle(8);
    bus.Enable = 1'b1;
    repeat (17 * 8 + 2) step();
    chk("sat_bits", int'(bus.Bit_Counts), 15);
    bus.Enable = 1'b0;
    step();
    chk("sat_clear", int'(bus.Bit_Counts), 0);

    // Enable drops on the vote cycle of bit 2: clear wins, Sampled_Bit holds.
    idle(8);
    pin = {1'b0, 1'b1, 8'h01, 1'b0};
    for (int t = 0; t < 22; t++) begin
      bus.RX_IN  = pin[t / 8];
      bus.Enable = (t >= 2);
      step();
    end
    chk("pre_drop_edge", int'(bus.Edge_Count), 4);
    chk("pre_drop_sampled", int'(bus.Sampled_Bit), 1);
    bus.Enable = 1'b0;
    step();
    chk("edrop_valid", int'(bus.Sample_Valid), 0);
    chk("edrop_edge", int'(bus.Edge_Count), 0);
    chk("edrop_bits", int'(bus.Bit_Counts), 0);
    chk("edrop_sampled", int'(bus.Sampled_Bit), 1);
    step();
    chk("edrop_valid2", int'(bus.Sample_Valid), 0);

    // Asynchronous reset in bit 4 of an all-zero frame.
    idle(8);
    pin = {1'b0, 1'b1, 8'h00, 1'b0};
    for (int t = 0; t < 36; t++) begin
      bus.RX_IN  = pin[t / 8];
      bus.Enable = (t >= 2);
      step();
    end
    chk("pre_rst_bits", int'(bus.Bit_Counts), 4);
    chk("pre_rst_sampled", int'(bus.Sampled_Bit), 0);
    #2 RST = 1'b0;
    #1;
    chk("arst_edge", int'(bus.Edge_Count), 0);
    chk("arst_bits", int'(bus.Bit_Counts), 0);
    chk("arst_sampled", int'(bus.Sampled_Bit), 1);
    chk("arst_valid", int'(bus.Sample_Valid), 0);
    chk("arst_rx_sync", int'(bus.RX_Sync), 1);
    bus.Enable = 1'b0;
    bus.RX_IN  = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    step();
    chk("post_rst_valid", int'(bus.Sample_Valid), 0);
    chk("post_rst_edge", int'(bus.Edge_Count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_bit_sampler.md
Name: rx_bit_sampler

Overview:
Upstream stage of the UART receiver, between the RX pin and the parity/stop/start checkers.
- Synchronises the serial line.
- Counts oversampling edges and bit positions.
- Takes three mid-bit samples and majority-votes them into Sampled_Bit.
- Drives Bit_Counts, which the downstream checkers use to decide which frame field the current bit belongs to.

Parameters:
PRESCALE_W, 6, width of Prescale and Edge_Count (covers oversampling ratios up to 32).

Ports:
CLK  input  1  oversampling clock (Prescale cycles per UART bit)
RST  input  1  asynchronous reset, active-low
RX_IN  input  1  raw serial line, idle high
Prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
Enable  input  1  from RX FSM; high while a frame is being received
RX_Sync  output  1  synchronised RX_IN, for FSM start-bit detection
Edge_Count  output  PRESCALE_W  oversampling edge index within the current bit
Bit_Counts  output  4  bit index in frame: 0 start, 1..8 data LSB-first, 9 parity, 9/10 stop
Sampled_Bit  output  1  majority-voted value of the last sampled bit
Sample_Valid  output  1  one-cycle pulse when Sampled_Bit updates

Behaviour:
- Reset values:
  - RX_Sync=1, sync flops=1.
  - Edge_Count=0, Bit_Counts=0.
  - Sampled_Bit=1, Sample_Valid=0.
  - Internal sample regs=1, latched prescale P=8.
- Prescale latch:
  - P is captured on the cycle Enable rises (Enable=1 while the previous Enable=0).
  - Prescale changes while Enable=1 are ignored.
  - Captured Prescale values below 8 are forced to P=8. Other non-power-of-2 values are used as-is, with H=P>>1.
- Counting while Enable=1:
  - Edge_Count increments every cycle and wraps from P-1 to 0.
  - On each wrap, Bit_Counts increments and saturates at 15.
- Counting while Enable=0:
  - Edge_Count=0 and Bit_Counts=0 next cycle.
  - Sample regs are cleared to 1.
  - Sampled_Bit holds its value.
- Sampling:
  - s0 is taken at Edge_Count=H-2 and s1 at H-1.
  - At Edge_Count=H, the third sample is the current RX_Sync. Sampled_Bit <= maj(s0,s1,RX_Sync) is registered at the end of that cycle.
  - Sample_Valid is high for exactly the following cycle, with Bit_Counts still equal to the index of the sampled bit.
- Latency: a pin change reaches RX_Sync after 2 CLK; mid-bit samples are therefore centred 2 cycles late.
- Boundaries:
  - If Enable falls in the same cycle as a sample point, the clear wins: no Sample_Valid is produced and Sampled_Bit is unchanged.
  - If Enable rises in the same cycle RX_Sync falls, the current cycle counts as Edge_Count=0.
  - RST asserted mid-frame returns all state to reset values immediately.
- No internal FSM beyond the counters. The FSM owns start/stop decisions and de-asserts Enable after the stop bit.

Optional Feature:
Macro RX_NOISE_FLAG_EN.
- Defined: adds output Noise_Flag (1 bit, reset 0), registered alongside Sampled_Bit. It is 1 when the three samples disagree (not all equal) and holds until the next Sample_Valid or until Enable=0.
- Undefined: no port, no logic, and the behaviour above is unchanged.

Decomposition:
- Shared package uart_rx_pkg holds:
  - BIT_START=4'd0, BIT_PARITY=4'd9, BIT_STOP_PAR=4'd10, BIT_STOP_NOPAR=4'd9.
  - PRESCALE_MIN=8, default PRESCALE_W.
  - The same package is used by the parity/stop/start checkers.
- Sub-module rx_sync: a 2-flop synchroniser with reset value 1, instantiated once for RX_IN.

Test Plan:
1. Reset, then drive RX_IN=1 with Enable=0 -> RX_Sync=1, Edge_Count=0, Bit_Counts=0, Sampled_Bit=1, Sample_Valid=0.
2. Prescale=8, Enable raised on the start edge, frame 0x55 with no parity -> 10 Sample_Valid pulses, 8 cycles apart; the first is at Edge_Count=5 of bit 0. Sampled_Bit sequence is 0,1,0,1,0,1,0,1,0,1 with Bit_Counts 0..9.
3. Prescale=16, frame 0xA3 with parity bit 0 -> pulses 16 cycles apart; Bit_Counts=9 pulse carries Sampled_Bit=0; Bit_Counts reaches 10 for the stop bit.
4. Prescale=8, one-cycle low glitch at Edge_Count=3 of a data-1 bit -> Sampled_Bit=1. With RX_NOISE_FLAG_EN defined, Noise_Flag=1 for that bit only.
5. Prescale changed from 8 to 32 mid-frame -> the period stays 8 until Enable drops; the next frame uses a period of 32.
6. Enable dropped on a sample cycle, and separately RST pulsed at Bit_Counts=4 -> no Sample_Valid in either case; counters are 0 next cycle; Sampled_Bit holds (Enable case) or is 1 (RST case).
